// File: rtl/crc_serial_engine_if.sv
// Handshake/data bundle for the bit-serial CRC engine.
// The requester drives start and the job operands. The engine returns
// busy, the done pulse and the registered result.
interface crc_serial_engine_if #(
    parameter int DATA_W = 6,
    parameter int CRC_W  = 5
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [LEN_W-1:0]  msg_len;
    logic [CRC_W-1:0]  crc_ref;
    logic              busy;
    logic              done;
    logic [CRC_W-1:0]  crc_out;
    logic              crc_match;

    modport master (
        output start, data_in, msg_len, crc_ref,
        input  busy, done, crc_out, crc_match
    );

    modport slave (
        input  start, data_in, msg_len, crc_ref,
        output busy, done, crc_out, crc_match
    );
endinterface

// File: rtl/crc_serial_engine.sv
// Bit-serial CRC engine built on a Galois LFSR.
// A job latches one message word and shifts it MSB-first, one bit per clock.
// When the last bit has been shifted, the final LFSR state (XOR XOR_OUT) is
// registered together with a compare against the latched reference CRC.
module crc_serial_engine #(
    parameter int               DATA_W  = 6,
    parameter int               CRC_W   = 5,
    parameter logic [CRC_W-1:0] POLY    = 5'b01011,
    parameter logic [CRC_W-1:0] INIT    = '0,
    parameter logic [CRC_W-1:0] XOR_OUT = '0
) (
    input  logic              clk,
    input  logic              reset,
    crc_serial_engine_if.slave bus
);
    localparam int               LEN_W    = $clog2(DATA_W + 1);
    localparam logic [LEN_W-1:0] FULL_LEN = LEN_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] msg_q;
    logic [CRC_W-1:0]  lfsr_q;
    logic [CRC_W-1:0]  ref_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [CRC_W-1:0]  crc_out_q;
    logic              match_q;

    logic              fb;
    logic [CRC_W-1:0]  lfsr_d;
    logic [CRC_W-1:0]  crc_final;
    logic [LEN_W-1:0]  len_d;

    // One LFSR step, the finished-result value and the clamped job length.
    always_comb begin
        fb        = msg_q[DATA_W-1] ^ lfsr_q[CRC_W-1];
        lfsr_d    = {lfsr_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
        crc_final = lfsr_d ^ XOR_OUT;
        // A zero or oversized length means "use the whole word".
        len_d     = (bus.msg_len == '0 || bus.msg_len > FULL_LEN) ? FULL_LEN : bus.msg_len;
    end

    // Job control FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            msg_q     <= '0;
            lfsr_q    <= '0;
            ref_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_out_q <= '0;
            match_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    msg_q  <= msg_q << 1;
                    lfsr_q <= lfsr_d;
                    cnt_q  <= cnt_q - 1'b1;
                    if (cnt_q == LEN_W'(1)) begin
                        // Last bit goes in on this edge, so publish the result now.
                        state_q   <= ST_DONE;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        crc_out_q <= crc_final;
                        match_q   <= (crc_final == ref_q);
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new job, which gives
                    // back-to-back operation without an idle gap.
                    done_q <= 1'b0;
                    if (bus.start) begin
                        state_q <= ST_SHIFT;
                        busy_q  <= 1'b1;
                        msg_q   <= bus.data_in;
                        lfsr_q  <= INIT;
                        ref_q   <= bus.crc_ref;
                        cnt_q   <= len_d;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.crc_match = match_q;
endmodule

// File: tb/tb_crc_serial_engine.sv
// Bench for crc_serial_engine: three instances (default config, XOR_OUT=1F,
// 16-bit data with CRC-8 poly 0x07). A cycle-level expectation model uses
// polynomial long division for the CRC value. Directed jobs also carry
// hand-computed literals.
module tb_crc_serial_engine;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    crc_serial_engine_if #(.DATA_W(6),  .CRC_W(5)) if0 ();
    crc_serial_engine_if #(.DATA_W(6),  .CRC_W(5)) if1 ();
    crc_serial_engine_if #(.DATA_W(16), .CRC_W(8)) if2 ();

    crc_serial_engine #(.DATA_W(6), .CRC_W(5), .POLY(5'b01011), .INIT(5'b0), .XOR_OUT(5'b0))
        dut0 (.clk(clk), .reset(rst), .bus(if0));
    crc_serial_engine #(.DATA_W(6), .CRC_W(5), .POLY(5'b01011), .INIT(5'b0), .XOR_OUT(5'b11111))
        dut1 (.clk(clk), .reset(rst), .bus(if1));
    crc_serial_engine #(.DATA_W(16), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOR_OUT(8'h00))
        dut2 (.clk(clk), .reset(rst), .bus(if2));

    // ---------------- comparison helper ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- CRC by polynomial long division ----------------
    // Remainder of (top len bits of data) * x^cw modulo (x^cw + poly), then XOR xo.
    function automatic longint crc_div(input longint data, input int dw, input int len,
                                       input int cw, input longint poly, input longint xo);
        longint m, d, g;
        int     l;
        l = (len == 0 || len > dw) ? dw : len;
        m = (data & ((longint'(1) << dw) - 1)) >> (dw - l);
        d = m << cw;
        g = (longint'(1) << cw) | poly;
        for (int i = l + cw - 1; i >= cw; i--)
            if (d[i]) d = d ^ (g << (i - cw));
        return (d & ((longint'(1) << cw) - 1)) ^ xo;
    endfunction

    function automatic int dw_of(input int k);
        return (k == 2) ? 16 : 6;
    endfunction

    function automatic int eff_len(input int k, input int l);
        return (l == 0 || l > dw_of(k)) ? dw_of(k) : l;
    endfunction

    // ---------------- DUT access helpers ----------------
    function automatic logic in_start(input int k);
        case (k)
            0: return if0.start;
            1: return if1.start;
            default: return if2.start;
        endcase
    endfunction
    function automatic longint in_data(input int k);
        case (k)
            0: return longint'(if0.data_in);
            1: return longint'(if1.data_in);
            default: return longint'(if2.data_in);
        endcase
    endfunction
    function automatic int in_len(input int k);
        case (k)
            0: return int'(if0.msg_len);
            1: return int'(if1.msg_len);
            default: return int'(if2.msg_len);
        endcase
    endfunction
    function automatic longint in_ref(input int k);
        case (k)
            0: return longint'(if0.crc_ref);
            1: return longint'(if1.crc_ref);
            default: return longint'(if2.crc_ref);
        endcase
    endfunction
    function automatic longint job_crc(input int k);
        case (k)
            0: return crc_div(in_data(0), 6, in_len(0), 5, 64'h0B, 64'h00);
            1: return crc_div(in_data(1), 6, in_len(1), 5, 64'h0B, 64'h1F);
            default: return crc_div(in_data(2), 16, in_len(2), 8, 64'h07, 64'h00);
        endcase
    endfunction
    function automatic logic o_busy(input int k);
        case (k) 0: return if0.busy; 1: return if1.busy; default: return if2.busy; endcase
    endfunction
    function automatic logic o_done(input int k);
        case (k) 0: return if0.done; 1: return if1.done; default: return if2.done; endcase
    endfunction
    function automatic logic o_match(input int k);
        case (k) 0: return if0.crc_match; 1: return if1.crc_match; default: return if2.crc_match; endcase
    endfunction
    function automatic longint o_crc(input int k);
        case (k)
            0: return longint'(if0.crc_out);
            1: return longint'(if1.crc_out);
            default: return longint'(if2.crc_out);
        endcase
    endfunction

    task automatic set_in(input int k, input logic [15:0] d, input logic [4:0] l, input logic [7:0] r);
        case (k)
            0: begin if0.data_in = d[5:0]; if0.msg_len = l[2:0]; if0.crc_ref = r[4:0]; end
            1: begin if1.data_in = d[5:0]; if1.msg_len = l[2:0]; if1.crc_ref = r[4:0]; end
            default: begin if2.data_in = d; if2.msg_len = l; if2.crc_ref = r; end
        endcase
    endtask
    task automatic set_start(input int k, input logic s);
        case (k)
            0: if0.start = s;
            1: if1.start = s;
            default: if2.start = s;
        endcase
    endtask

    // ---------------- expectation model ----------------
    // m_rem: shift cycles left in the current job (0 = not busy).
    int     m_rem   [3] = '{0, 0, 0};
    logic   m_done  [3] = '{1'b0, 1'b0, 1'b0};
    longint m_crc   [3] = '{0, 0, 0};
    logic   m_match [3] = '{1'b0, 1'b0, 1'b0};
    longint j_crc   [3] = '{0, 0, 0};
    longint j_ref   [3] = '{0, 0, 0};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                m_rem[k]   <= 0;
                m_done[k]  <= 1'b0;
                m_crc[k]   <= 0;
                m_match[k] <= 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (m_rem[k] > 0) begin
                    m_rem[k]  <= m_rem[k] - 1;
                    m_done[k] <= (m_rem[k] == 1);
                    if (m_rem[k] == 1) begin
                        m_crc[k]   <= j_crc[k];
                        m_match[k] <= (j_crc[k] == j_ref[k]);
                    end
                end else begin
                    m_done[k] <= 1'b0;
                    if (in_start(k)) begin
                        m_rem[k] <= eff_len(k, in_len(k));
                        j_crc[k] <= job_crc(k);
                        j_ref[k] <= in_ref(k);
                    end
                end
            end
        end
    end

    // Compare every DUT against the model on every falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("busy%0d", k),      o_busy(k),  m_rem[k] > 0);
            chk($sformatf("done%0d", k),      o_done(k),  m_done[k]);
            chk($sformatf("crc_out%0d", k),   o_crc(k),   m_crc[k]);
            chk($sformatf("crc_match%0d", k), o_match(k), m_match[k]);
        end
    end

    // Runs one job starting at posedge+2; returns at posedge+2 of the DONE cycle,
    // so a follow-up call produces a back-to-back start.
    task automatic run(input int k, input logic [15:0] d, input logic [4:0] l,
                       input logic [7:0] r, input longint exp_crc, input logic exp_match,
                       input logic extra, input string nm);
        int len;
        len = eff_len(k, int'(l));
        set_in(k, d, l, r);
        set_start(k, 1'b1);
        @(posedge clk); #2;
        chk({nm, "_busy_after_start"}, o_busy(k), 1'b1);
        if (!extra) set_start(k, 1'b0);
        repeat (len - 1) begin
            @(posedge clk); #2;
            set_start(k, 1'b0);
        end
        @(posedge clk); #1;
        chk({nm, "_done"},  o_done(k),  1'b1);
        chk({nm, "_busy"},  o_busy(k),  1'b0);
        chk({nm, "_crc"},   o_crc(k),   exp_crc);
        chk({nm, "_match"}, o_match(k), exp_match);
        $display("job %s dut=%0d data=%0h len=%0d ref=%0h crc_out=%0h match=%0b", nm, k, d, len, r,
                 o_crc(k), o_match(k));
        #1;
    endtask

    task automatic gap();
        @(posedge clk); #2;
    endtask

    initial begin
        logic [15:0] rd;
        logic [4:0]  rl;
        logic [7:0]  rr;
        longint      ec;

        for (int k = 0; k < 3; k++) begin
            set_start(k, 1'b0);
            set_in(k, 16'h0, 5'h0, 8'h0);
        end
        #1 rst = 1'b1;

        // Pin the division model with hand-computed values.
        chk("model_s1",   crc_div(64'b101101, 6, 0, 5, 64'h0B, 64'h00), 64'b10001);
        chk("model_s2",   crc_div(64'b100000, 6, 1, 5, 64'h0B, 64'h00), 64'b01011);
        chk("model_xo",   crc_div(64'b101101, 6, 6, 5, 64'h0B, 64'h1F), 64'b01110);
        chk("model_crc8", crc_div(64'h0100, 16, 16, 8, 64'h07, 64'h00), 64'h15);
        chk("model_len8", crc_div(64'h0100, 16, 8, 8, 64'h07, 64'h00), 64'h07);

        #2;
        chk("reset_busy", if0.busy, 1'b0);
        chk("reset_done", if0.done, 1'b0);
        chk("reset_crc",  if0.crc_out, 5'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        gap();

        // Full-length job, then a one-bit job.
        run(0, 16'b101101, 5'd0, 8'h00, 64'b10001, 1'b0, 1'b0, "s1");
        gap();
        run(0, 16'b100000, 5'd1, 8'h0B, 64'b01011, 1'b1, 1'b0, "s2");
        gap();

        // XOR_OUT instance: matching and non-matching references.
        run(1, 16'b101101, 5'd0, 8'b01110, 64'b01110, 1'b1, 1'b0, "s3_match");
        gap();
        run(1, 16'b101101, 5'd0, 8'b01111, 64'b01110, 1'b0, 1'b0, "s3_nomatch");
        gap();

        // Abort mid-shift with reset: outputs clear at once, no done follows.
        set_in(0, 16'b110011, 5'd0, 8'h00);
        set_start(0, 1'b1);
        @(posedge clk); #2;
        set_start(0, 1'b0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy",  if0.busy, 1'b0);
        chk("abort_done",  if0.done, 1'b0);
        chk("abort_crc",   if0.crc_out, 5'b0);
        chk("abort_match", if0.crc_match, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #2;
            chk("abort_nodone", if0.done, 1'b0);
        end
        run(0, 16'b101101, 5'd0, 8'h00, 64'b10001, 1'b0, 1'b0, "s5_after");
        gap();

        // Back-to-back: job B starts during A's done cycle; B holds start while busy.
        run(0, 16'b101101, 5'd0, 8'b10001, 64'b10001, 1'b1, 1'b0, "s4_A");
        run(0, 16'b000000, 5'd0, 8'h00, 64'b00000, 1'b1, 1'b1, "s4_B");
        gap();

        // Random jobs on the 16-bit CRC-8 instance, including oversized lengths.
        for (int i = 0; i < 20; i++) begin
            rd = 16'($urandom);
            rl = 5'($urandom_range(0, 20));
            ec = crc_div(longint'(rd), 16, int'(rl), 8, 64'h07, 64'h00);
            rr = (i % 3 == 0) ? 8'(ec) : 8'($urandom);
            run(2, rd, rl, rr, ec, (longint'(rr) == ec), 1'($urandom_range(0, 1)),
                $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) gap();
        end

        repeat (3) @(posedge clk);
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
